// File: rtl/abro_checker_if.sv
// ----------------------------------------------------------------------------
// abro_checker_if : observed ABRO stimulus/response plus checker results. rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface abro_checker_if #(
  parameter int CNT_W = 16
) ();
  logic             R;
  logic             A;
  logic             B;
  logic             O;
  logic [1:0]       State;
  logic             exp_o;
  logic [1:0]       exp_state;
  logic             armed;
  logic             mis_pulse;
  logic             err_o;
  logic             err_state;
  logic [CNT_W-1:0] first_err_cyc;
  logic [CNT_W-1:0] cmp_count;
  logic [CNT_W-1:0] o_count;

  modport master (
    output R, A, B, O, State,
    input  exp_o, exp_state, armed, mis_pulse, err_o, err_state,
    input  first_err_cyc, cmp_count, o_count
  );

  modport slave (
    input  R, A, B, O, State,
    output exp_o, exp_state, armed, mis_pulse, err_o, err_state,
    output first_err_cyc, cmp_count, o_count
  );
endinterface

`default_nettype wire

// File: rtl/abro_checker.sv
// ----------------------------------------------------------------------------
// abro_checker : cycle-accurate ABRO golden model comparing a DUT's O/State. rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module abro_checker #(
  parameter int CNT_W       = 16,
  parameter bit CHECK_STATE = 1'b1
) (
  input  wire logic       clk,
  input  wire logic       rst,
  abro_checker_if.slave   bus
);

  typedef enum logic [1:0] {
    WAIT_AB = 2'b00,
    GOT_A   = 2'b01,
    GOT_B   = 2'b10,
    DONE    = 2'b11
  } abro_state_t;

  localparam logic [CNT_W-1:0] c_cnt_max = '1;

  abro_state_t      r_state;
  abro_state_t      w_state_nxt;
  logic             r_exp_o;
  logic             w_exp_o_nxt;
  logic             r_armed;
  logic             r_mis;
  logic             r_err_o;
  logic             r_err_s;
  logic [CNT_W-1:0] r_first;
  logic [CNT_W-1:0] r_cmp;
  logic [CNT_W-1:0] r_ocnt;
  logic             w_m_o;
  logic             w_m_s;
  logic             w_mis;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= WAIT_AB;
      r_exp_o <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_exp_o <= w_exp_o_nxt;
    end
  end

  // The model stays frozen until armed; only R may move it before then.
  always_comb begin
    w_state_nxt = r_state;
    w_exp_o_nxt = r_exp_o;
    if (bus.R) begin
      w_state_nxt = WAIT_AB;
      w_exp_o_nxt = 1'b0;
    end else if (r_armed) begin
      case (r_state)
        WAIT_AB: begin
          if (bus.A && bus.B) w_state_nxt = DONE;
          else if (bus.A)     w_state_nxt = GOT_A;
          else if (bus.B)     w_state_nxt = GOT_B;
        end
        GOT_A:   if (bus.B) w_state_nxt = DONE;
        GOT_B:   if (bus.A) w_state_nxt = DONE;
        default: w_state_nxt = DONE;
      endcase
      w_exp_o_nxt = (w_state_nxt == DONE) && (r_state != DONE);
    end
  end

  always_comb begin
    w_m_o = r_armed && (bus.O != r_exp_o);
    w_m_s = r_armed && CHECK_STATE && (bus.State != r_state);
    w_mis = w_m_o || w_m_s;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_armed <= 1'b0;
      r_mis   <= 1'b0;
      r_err_o <= 1'b0;
      r_err_s <= 1'b0;
      r_first <= '0;
      r_cmp   <= '0;
      r_ocnt  <= '0;
    end else begin
      if (bus.R) r_armed <= 1'b1;
      r_mis <= w_mis;
      if (r_armed) begin
        if (r_cmp != c_cnt_max)           r_cmp  <= r_cmp + 1'b1;
        if (bus.O && r_ocnt != c_cnt_max) r_ocnt <= r_ocnt + 1'b1;
      end
      if (w_m_o) r_err_o <= 1'b1;
      if (w_m_s) r_err_s <= 1'b1;
      // First error captures the pre-increment compare index.
      if (w_mis && !r_err_o && !r_err_s) r_first <= r_cmp;
    end
  end

  assign bus.exp_o         = r_exp_o;
  assign bus.exp_state     = r_state;
  assign bus.armed         = r_armed;
  assign bus.mis_pulse     = r_mis;
  assign bus.err_o         = r_err_o;
  assign bus.err_state     = r_err_s;
  assign bus.first_err_cyc = r_first;
  assign bus.cmp_count     = r_cmp;
  assign bus.o_count       = r_ocnt;

endmodule

`default_nettype wire

// File: tb/tb_abro_checker.sv
// ----------------------------------------------------------------------------
// tb_abro_checker : directed and randomized checks against a flag-based ABRO model. rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_abro_checker;
  localparam int CW = 6;
  localparam int VW = 7 + 3 * CW;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic t_rst, t_r, t_a, t_b, t_o;
  logic [1:0] t_state;

  abro_checker_if #(.CNT_W(CW)) bus0 ();
  abro_checker_if #(.CNT_W(CW)) bus1 ();

  assign bus0.R = t_r;  assign bus0.A = t_a;  assign bus0.B = t_b;
  assign bus0.O = t_o;  assign bus0.State = t_state;
  assign bus1.R = t_r;  assign bus1.A = t_a;  assign bus1.B = t_b;
  assign bus1.O = t_o;  assign bus1.State = t_state;

  abro_checker #(.CNT_W(CW), .CHECK_STATE(1'b1)) u_dut0 (.clk(clk), .rst(t_rst), .bus(bus0));
  abro_checker #(.CNT_W(CW), .CHECK_STATE(1'b0)) u_dut1 (.clk(clk), .rst(t_rst), .bus(bus1));

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: ABRO as "A seen" / "B seen" flags; DONE means both seen.
  logic          m_armed, m_sa, m_sb, m_eo, m_mis0, m_mis1, m_err_o, m_err_s;
  logic [CW-1:0] m_first0, m_first1, m_cmp, m_ocnt;

  // Drives one cycle; O/State follow the model (a correct DUT) xor the given faults.
  task automatic step(input logic r_i, input logic a_i, input logic b_i,
                      input logic fo, input logic [1:0] fs, input logic rs);
    logic mo, ms, was_done;
    @(negedge clk);
    t_rst = rs; t_r = r_i; t_a = a_i; t_b = b_i;
    t_o = m_eo ^ fo;
    t_state = {m_sb, m_sa} ^ fs;
    @(posedge clk);
    if (t_rst) begin
      m_armed = 0; m_sa = 0; m_sb = 0; m_eo = 0; m_mis0 = 0; m_mis1 = 0;
      m_err_o = 0; m_err_s = 0; m_first0 = '0; m_first1 = '0; m_cmp = '0; m_ocnt = '0;
    end else if (!m_armed) begin
      m_mis0 = 0; m_mis1 = 0;
      if (t_r) begin m_armed = 1; m_sa = 0; m_sb = 0; m_eo = 0; end
    end else begin
      mo = (t_o !== m_eo);
      ms = (t_state !== {m_sb, m_sa});
      m_mis0 = mo || ms;
      m_mis1 = mo;
      if ((mo || ms) && !m_err_o && !m_err_s) m_first0 = m_cmp;
      if (mo && !m_err_o) m_first1 = m_cmp;
      m_err_o = m_err_o | mo;
      m_err_s = m_err_s | ms;
      if (m_cmp != {CW{1'b1}}) m_cmp = m_cmp + 1'b1;
      if (t_o && m_ocnt != {CW{1'b1}}) m_ocnt = m_ocnt + 1'b1;
      was_done = m_sa && m_sb;
      if (t_r) begin m_sa = 0; m_sb = 0; end
      else begin m_sa = m_sa | t_a; m_sb = m_sb | t_b; end
      m_eo = !t_r && m_sa && m_sb && !was_done;
    end
    #1;
  endtask

  task automatic test_reset();
    logic [VW-1:0] act;
    step($urandom_range(0, 1), 1, 1, 1, 2'b11, 1);
    step(1, 1, 0, 0, 2'b00, 1);
    act = {bus0.exp_o, bus0.exp_state, bus0.armed, bus0.mis_pulse, bus0.err_o,
           bus0.err_state, bus0.first_err_cyc, bus0.cmp_count, bus0.o_count};
    n_checks++;
    if (act !== '0) $display("FAIL reset_dut0: got %h want 0", act); else n_pass++;
    act = {bus1.exp_o, bus1.exp_state, bus1.armed, bus1.mis_pulse, bus1.err_o,
           bus1.err_state, bus1.first_err_cyc, bus1.cmp_count, bus1.o_count};
    n_checks++;
    if (act !== '0) $display("FAIL reset_dut1: got %h want 0", act); else n_pass++;
  endtask

  task automatic test_arm();
    step(0, 0, 0, 0, 2'b00, 1);
    step(1, 0, 0, 0, 2'b00, 0);
    n_checks++;
    if (bus0.armed !== 1'b1 || bus0.cmp_count !== 0)
      $display("FAIL arm_edge: armed=%b cmp=%0d want armed=1 cmp=0", bus0.armed, bus0.cmp_count);
    else n_pass++;
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 2'b00, 0);
    n_checks++;
    if (bus0.cmp_count !== 3) $display("FAIL arm_cmp: got %0d want 3", bus0.cmp_count); else n_pass++;
    n_checks++;
    if ({bus0.armed, bus0.exp_state, bus0.err_o, bus0.err_state} !== 5'b10000)
      $display("FAIL arm_flags: armed=%b st=%b err_o=%b err_s=%b want 1 00 0 0",
               bus0.armed, bus0.exp_state, bus0.err_o, bus0.err_state);
    else n_pass++;
  endtask

  task automatic test_a_then_b();
    step(0, 0, 0, 0, 2'b00, 1);
    step(1, 0, 0, 0, 2'b00, 0);
    step(0, 1, 0, 0, 2'b00, 0);
    n_checks++;
    if ({bus0.exp_state, bus0.exp_o} !== 3'b010)
      $display("FAIL ab_after_a: st=%b eo=%b want 01 0", bus0.exp_state, bus0.exp_o); else n_pass++;
    step(0, 0, 0, 0, 2'b00, 0);
    n_checks++;
    if (bus0.exp_state !== 2'b01) $display("FAIL ab_idle: st=%b want 01", bus0.exp_state); else n_pass++;
    step(0, 0, 1, 0, 2'b00, 0);
    n_checks++;
    if ({bus0.exp_state, bus0.exp_o} !== 3'b111)
      $display("FAIL ab_after_b: st=%b eo=%b want 11 1", bus0.exp_state, bus0.exp_o); else n_pass++;
    step(0, 0, 0, 0, 2'b00, 0);
    n_checks++;
    if ({bus0.exp_state, bus0.exp_o} !== 3'b110 || bus0.o_count !== 1)
      $display("FAIL ab_pulse_end: st=%b eo=%b ocnt=%0d want 11 0 1",
               bus0.exp_state, bus0.exp_o, bus0.o_count);
    else n_pass++;
    step(0, 1, 1, 0, 2'b00, 0);
    n_checks++;
    if ({bus0.exp_o, bus0.o_count, bus0.err_o, bus0.err_state, bus0.mis_pulse} !== {1'b0, 6'd1, 3'b000})
      $display("FAIL ab_done_hold: eo=%b ocnt=%0d err_o=%b err_s=%b mis=%b want 0 1 0 0 0",
               bus0.exp_o, bus0.o_count, bus0.err_o, bus0.err_state, bus0.mis_pulse);
    else n_pass++;
  endtask

  task automatic test_ab_same_cycle();
    step(0, 0, 0, 0, 2'b00, 1);
    step(1, 0, 0, 0, 2'b00, 0);
    step(0, 1, 1, 0, 2'b00, 0);
    n_checks++;
    if ({bus0.exp_state, bus0.exp_o} !== 3'b111)
      $display("FAIL abs_done: st=%b eo=%b want 11 1", bus0.exp_state, bus0.exp_o); else n_pass++;
    step(1, 1, 1, 0, 2'b00, 0);
    n_checks++;
    if ({bus0.exp_state, bus0.exp_o, bus0.err_o} !== 4'b0000)
      $display("FAIL abs_rearm: st=%b eo=%b err_o=%b want 00 0 0", bus0.exp_state, bus0.exp_o, bus0.err_o);
    else n_pass++;
  endtask

  task automatic test_o_fault();
    step(0, 0, 0, 0, 2'b00, 1);
    step(1, 0, 0, 0, 2'b00, 0);
    step(0, 1, 1, 0, 2'b00, 0);
    step(0, 0, 0, 0, 2'b00, 0);
    step(0, 0, 0, 1, 2'b00, 0);
    n_checks++;
    if ({bus0.mis_pulse, bus0.err_o, bus0.err_state} !== 3'b110 || bus0.first_err_cyc !== 2)
      $display("FAIL ofault_hit: mis=%b err_o=%b err_s=%b first=%0d want 1 1 0 2",
               bus0.mis_pulse, bus0.err_o, bus0.err_state, bus0.first_err_cyc);
    else n_pass++;
    step(0, 0, 0, 0, 2'b00, 0);
    step(0, 0, 0, 0, 2'b00, 0);
    n_checks++;
    if ({bus0.mis_pulse, bus0.err_o} !== 2'b01 || bus0.first_err_cyc !== 2 || bus0.cmp_count !== 5)
      $display("FAIL ofault_hold: mis=%b err_o=%b first=%0d cmp=%0d want 0 1 2 5",
               bus0.mis_pulse, bus0.err_o, bus0.first_err_cyc, bus0.cmp_count);
    else n_pass++;
  endtask

  task automatic test_state_fault();
    step(0, 0, 0, 0, 2'b00, 1);
    step(1, 0, 0, 0, 2'b00, 0);
    step(0, 1, 0, 0, 2'b00, 0);
    step(0, 0, 0, 0, 2'b11, 0);
    n_checks++;
    if ({bus0.err_state, bus0.err_o, bus0.mis_pulse} !== 3'b101)
      $display("FAIL sfault_chk1: err_s=%b err_o=%b mis=%b want 1 0 1",
               bus0.err_state, bus0.err_o, bus0.mis_pulse);
    else n_pass++;
    n_checks++;
    if ({bus1.err_state, bus1.err_o, bus1.mis_pulse} !== 3'b000)
      $display("FAIL sfault_chk0: err_s=%b err_o=%b mis=%b want 0 0 0",
               bus1.err_state, bus1.err_o, bus1.mis_pulse);
    else n_pass++;
  endtask

  task automatic test_reset_midrun();
    step(0, 0, 0, 0, 2'b00, 1);
    for (int i = 0; i < 4; i++) step(0, 1, 1, 1, 2'b10, 0);
    n_checks++;
    if ({bus0.armed, bus0.mis_pulse, bus0.err_o, bus0.err_state} !== 4'b0000 ||
        bus0.cmp_count !== 0 || bus0.o_count !== 0 || bus0.exp_state !== 2'b00)
      $display("FAIL mid_prearm: armed=%b cmp=%0d ocnt=%0d st=%b want 0 0 0 00",
               bus0.armed, bus0.cmp_count, bus0.o_count, bus0.exp_state);
    else n_pass++;
    step(1, 0, 0, 0, 2'b00, 0);
    step(0, 1, 0, 1, 2'b00, 0);
    step(0, 0, 0, 0, 2'b00, 0);
    step(1, 1, 1, 1, 2'b01, 1);
    n_checks++;
    if ({bus0.exp_o, bus0.exp_state, bus0.armed, bus0.mis_pulse, bus0.err_o, bus0.err_state,
         bus0.first_err_cyc, bus0.cmp_count, bus0.o_count} !== '0)
      $display("FAIL mid_reset: got armed=%b err_o=%b cmp=%0d want all zero",
               bus0.armed, bus0.err_o, bus0.cmp_count);
    else n_pass++;
    for (int i = 0; i < 3; i++) step(0, 1, 0, 1, 2'b00, 0);
    n_checks++;
    if (bus0.armed !== 1'b0 || bus0.cmp_count !== 0 || bus0.err_o !== 1'b0)
      $display("FAIL mid_noresume: armed=%b cmp=%0d err_o=%b want 0 0 0",
               bus0.armed, bus0.cmp_count, bus0.err_o);
    else n_pass++;
    step(1, 0, 0, 0, 2'b00, 0);
    step(0, 0, 0, 0, 2'b00, 0);
    n_checks++;
    if (bus0.armed !== 1'b1 || bus0.cmp_count !== 1)
      $display("FAIL mid_resume: armed=%b cmp=%0d want 1 1", bus0.armed, bus0.cmp_count);
    else n_pass++;
  endtask

  task automatic test_saturation();
    step(0, 0, 0, 0, 2'b00, 1);
    step(1, 0, 0, 0, 2'b00, 0);
    for (int i = 0; i < 70; i++) step(0, 0, 0, 1, 2'b00, 0);
    n_checks++;
    if (bus0.cmp_count !== {CW{1'b1}} || bus0.o_count !== {CW{1'b1}} || bus0.first_err_cyc !== 0)
      $display("FAIL sat: cmp=%0d ocnt=%0d first=%0d want %0d %0d 0",
               bus0.cmp_count, bus0.o_count, bus0.first_err_cyc, (1 << CW) - 1, (1 << CW) - 1);
    else n_pass++;
  endtask

  task automatic test_random();
    logic [VW-1:0] act0, exp0;
    logic [3+3*CW-1:0] act1, exp1;
    logic fo;
    logic [1:0] fs;
    step(0, 0, 0, 0, 2'b00, 1);
    for (int i = 0; i < 300; i++) begin
      fo = ($urandom_range(0, 19) == 0);
      fs = ($urandom_range(0, 19) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      step($urandom_range(0, 7) == 0, $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0,
           fo, fs, $urandom_range(0, 59) == 0);
      act0 = {bus0.exp_o, bus0.exp_state, bus0.armed, bus0.mis_pulse, bus0.err_o,
              bus0.err_state, bus0.first_err_cyc, bus0.cmp_count, bus0.o_count};
      exp0 = {m_eo, m_sb, m_sa, m_armed, m_mis0, m_err_o, m_err_s, m_first0, m_cmp, m_ocnt};
      n_checks++;
      if (act0 !== exp0) $display("FAIL rand_dut0 cyc %0d: got %h want %h", i, act0, exp0);
      else n_pass++;
      act1 = {bus1.mis_pulse, bus1.err_o, bus1.err_state, bus1.first_err_cyc,
              bus1.cmp_count, bus1.o_count};
      exp1 = {m_mis1, m_err_o, 1'b0, m_first1, m_cmp, m_ocnt};
      n_checks++;
      if (act1 !== exp1) $display("FAIL rand_dut1 cyc %0d: got %h want %h", i, act1, exp1);
      else n_pass++;
    end
  endtask

  initial begin
    t_rst = 1'b1; t_r = 1'b0; t_a = 1'b0; t_b = 1'b0; t_o = 1'b0; t_state = 2'b00;
    m_armed = 0; m_sa = 0; m_sb = 0; m_eo = 0; m_mis0 = 0; m_mis1 = 0;
    m_err_o = 0; m_err_s = 0; m_first0 = '0; m_first1 = '0; m_cmp = '0; m_ocnt = '0;
    test_reset();
    test_arm();
    test_a_then_b();
    test_ab_same_cycle();
    test_o_fault();
    test_state_fault();
    test_reset_midrun();
    test_saturation();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/abro_checker.md
# abro_checker

Synthesizable golden-model checker that sits beside the ABROStateMachine and watches its stimulus (R, A, B) and its responses (O, State) on the same clock. It runs its own cycle-accurate ABRO model, compares expected against observed every cycle, and reports per-cycle mismatch pulses, sticky error flags and event counters. It serves as the receiving/checking end of the ABRO interface, in simulation and in FPGA bring-up.

## Interface
- CNT_W, 16: width of all event counters; counters saturate at 2^CNT_W-1.
- CHECK_STATE, 1: 1 = compare State as well as O; 0 = compare O only.

- Clock  in  1  single clock, shared with the DUT; all logic on posedge.
- Reset  in  1  checker reset; synchronous, active-high; clears model, flags and counters.
- R  in  1  ABRO reset input as driven to the DUT (observed, not generated).
- A  in  1  ABRO input A as driven to the DUT.
- B  in  1  ABRO input B as driven to the DUT.
- O  in  1  DUT output O.
- State  in  2  DUT state output.
- exp_o  out  1  model's expected O for the current cycle.
- exp_state  out  2  model's expected State for the current cycle.
- armed  out  1  model synchronized; comparisons active.
- mis_pulse  out  1  one-cycle pulse: mismatch detected at the previous edge.
- err_o  out  1  sticky: any O mismatch since Reset.
- err_state  out  1  sticky: any State mismatch since Reset (always 0 if CHECK_STATE=0).
- first_err_cyc  out  CNT_W  value of cmp_count at the first mismatch; holds afterward.
- cmp_count  out  CNT_W  number of compared cycles.
- o_count  out  CNT_W  number of cycles with observed O=1.

## Operation
- Model states and encoding: WAIT_AB=2'b00, GOT_A=2'b01, GOT_B=2'b10, DONE=2'b11.
- Model transitions at each posedge:
  - R=1: WAIT_AB from any state.
  - WAIT_AB: A&B goes to DONE; A only goes to GOT_A; B only goes to GOT_B; else stay.
  - GOT_A: B goes to DONE; else stay.
  - GOT_B: A goes to DONE; else stay.
  - DONE: stay until R.
- exp_o is registered. It is 1 only in the cycle directly after the edge that enters DONE from a non-DONE state (one-cycle pulse). It is 0 in all other cycles, including when R=1.
- R has priority over A and B in the same cycle.
- Arming: after Reset, armed=0. The first edge sampling R=1 loads the model to WAIT_AB, and armed=1 from the next cycle. Before that, no comparisons run and no counters change.
- Compare: at each posedge with armed=1 and Reset=0, the checker samples the mismatch m_o = (O != exp_o) and m_s = CHECK_STATE & (State != exp_state). cmp_count increments. If O=1, o_count increments.
- On m_o or m_s:
  - mis_pulse is set for one cycle.
  - err_o and/or err_state are set and stay set.
  - On the first error only, first_err_cyc latches cmp_count, taking its pre-increment value.
- The model never re-syncs to the DUT after a mismatch; it follows the observed R, A and B only.
- Counters saturate and do not wrap. Sticky flags clear only on Reset.

## Timing
- Reset values: exp_state=00, exp_o=0, armed=0, mis_pulse=0, err_o=0, err_state=0, first_err_cyc=0, cmp_count=0, o_count=0.
- Reset is sampled at posedge and takes priority over everything, including an R, A or B in the same cycle.
- Model latency matches the DUT: inputs sampled at edge k show up in exp_state/exp_o after edge k.
- Mismatch latency: a mismatch visible in cycle k is compared at edge k+1, so mis_pulse and the flags are high after edge k+1.
- A Reset asserted mid-sequence drops armed. A fresh R=1 is required before checking resumes.
- An R=1 observed while armed re-initializes the model only; counters and flags are kept.
- Simultaneous A&B from GOT_A or GOT_B: goes to DONE (B or A respectively is sufficient).

## Test plan
- Reset, then R=1 for 1 cycle, then idle 3 cycles with a correct DUT -> armed=1, exp_state=00, cmp_count=3, err_o=0, err_state=0.
- Sequence A, then idle, then B with a correct DUT -> exp_state goes 01 then 11; exp_o=1 for exactly one cycle; o_count=1; no errors.
- A&B in the same cycle from WAIT_AB -> exp_state=11 next cycle, exp_o pulse; then R=1 -> exp_state=00, exp_o=0.
- Faulty DUT holding O=1 for two cycles in DONE -> mis_pulse once, err_o=1, err_state=0, first_err_cyc equals the compare index of the second O cycle.
- CHECK_STATE=1 with DUT State forced to 10 while the model is at 01 -> err_state=1 and err_o=0. Same stimulus with CHECK_STATE=0 -> no error.
- Activity before any R=1, with Reset asserted mid-run -> no compares while armed=0; after Reset, all outputs return to their reset values, and checking resumes only after the next R=1.
